imem_loader: RTL and testbench

//  Sequential writer for the instruction memory: receives a program as a byte stream and writes it

---
 rtl/imem_pkg.sv | 16 +
 rtl/byte_assembler.sv | 42 ++++
 rtl/imem_loader.sv | 128 ++++++++++++
 tb/tb_imem_loader.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and defaults for the instruction-memory loader.
// IMEM_LOADER_CHECKSUM_EN adds the trailing-checksum CHECK state.
package imem_pkg;
    localparam int DEF_TAM_POSICIONES = 1024;
    localparam int DEF_TAM_PALABRA    = 32;

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, COLLECT, WRITE, CHECK, FIN} state_t;
`else
    typedef enum logic [2:0] {IDLE, COLLECT, WRITE, FIN} state_t;
`endif

    function automatic int bpw(input int tam_palabra);
        return tam_palabra / 8;
    endfunction
endpackage

// File: rtl/byte_assembler.sv
// Packs a byte stream little-endian into one word; word_full flags the
// handshake of the final byte, with the completed word on `merged`.
module byte_assembler
    import imem_pkg::*;
#(
    parameter int TAM_PALABRA = DEF_TAM_PALABRA
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   clear,
    input  logic                   take,
    input  logic [7:0]             byte_in,
    output logic                   word_full,
    output logic [TAM_PALABRA-1:0] merged
);
    localparam int BPW = bpw(TAM_PALABRA);
    localparam int IW  = (BPW > 1) ? $clog2(BPW) : 1;

    logic [IW-1:0]          idx;
    logic [TAM_PALABRA-1:0] acc;

    assign word_full = take && (idx == IW'(BPW - 1));

    // Current byte merged in combinationally so the full word is usable on the last handshake.
    always_comb begin
        merged = acc;
        merged[idx*8 +: 8] = byte_in;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            idx <= '0;
            acc <= '0;
        end else if (clear) begin
            idx <= '0;
            acc <= '0;
        end else if (take) begin
            acc <= merged;
            idx <= word_full ? '0 : idx + 1'b1;
        end
    end
endmodule

// File: rtl/imem_loader.sv
// Byte-stream loader that writes a program word by word into instruction memory
// from address 0, stalling the core meanwhile. Optional checksum: IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_pkg::*;
#(
    parameter int TAM_POSICIONES = DEF_TAM_POSICIONES,
    parameter int TAM_PALABRA    = DEF_TAM_PALABRA
) (
    input  logic                              CLK,
    input  logic                              RST_N,
    input  logic                              START,
    input  logic [$clog2(TAM_POSICIONES):0]   LOAD_LEN,
    input  logic                              BYTE_VALID,
    input  logic [7:0]                        BYTE_DATA,
    output logic                              BYTE_READY,
    output logic                              WE,
    output logic [$clog2(TAM_POSICIONES)-1:0] WR_ADDRESS,
    output logic [TAM_PALABRA-1:0]            WR_DATA,
    output logic                              BUSY,
    output logic                              CPU_HOLD,
    output logic                              DONE,
    output logic                              CHK_ERR
);
    localparam int AW = $clog2(TAM_POSICIONES);
    localparam logic [AW:0] MAX_LEN = (AW+1)'(TAM_POSICIONES);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t END_STATE = CHECK;
`else
    localparam state_t END_STATE = FIN;
`endif

    state_t                 state, next;
    logic [AW-1:0]          word_cnt, last_idx;
    logic [AW:0]            eff_len;
    logic                   start_ok, take, take_data, word_full;
    logic [TAM_PALABRA-1:0] merged;

    assign take      = BYTE_VALID && BYTE_READY;
    assign take_data = take && (state == COLLECT);
    assign start_ok  = START && (state == IDLE || state == FIN);
    assign eff_len   = (LOAD_LEN > MAX_LEN) ? MAX_LEN : LOAD_LEN;
    assign CPU_HOLD  = BUSY;

    byte_assembler #(.TAM_PALABRA(TAM_PALABRA)) u_asm (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .clear     (start_ok),
        .take      (take_data),
        .byte_in   (BYTE_DATA),
        .word_full (word_full),
        .merged    (merged)
    );

    always_comb begin
        next       = state;
        BYTE_READY = 1'b0;
        WE         = 1'b0;
        BUSY       = 1'b0;
        DONE       = 1'b0;
        case (state)
            IDLE, FIN: begin
                DONE = (state == FIN);
                if (START) next = (LOAD_LEN == '0) ? END_STATE : COLLECT;
            end
            COLLECT: begin
                BUSY       = 1'b1;
                BYTE_READY = 1'b1;
                if (word_full) next = WRITE;
            end
            WRITE: begin
                BUSY = 1'b1;
                WE   = 1'b1;
                next = (word_cnt == last_idx) ? END_STATE : COLLECT;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK: begin
                BUSY       = 1'b1;
                BYTE_READY = 1'b1;
                if (BYTE_VALID) next = FIN;
            end
`endif
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            word_cnt   <= '0;
            last_idx   <= '0;
            WR_ADDRESS <= '0;
            WR_DATA    <= '0;
        end else begin
            state <= next;
            if (start_ok) begin
                word_cnt <= '0;
                last_idx <= AW'(eff_len - 1'b1);
            end else if (state == WRITE && word_cnt != last_idx) begin
                word_cnt <= word_cnt + 1'b1;
            end
            // Registered here so address/data stay put outside the WRITE cycle.
            if (word_full) begin
                WR_ADDRESS <= word_cnt;
                WR_DATA    <= merged;
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] sum;
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sum     <= '0;
            CHK_ERR <= 1'b0;
        end else if (start_ok) begin
            sum     <= '0;
            CHK_ERR <= 1'b0;
        end else if (take_data) begin
            sum <= sum + BYTE_DATA;
        end else if (state == CHECK && take) begin
            CHK_ERR <= ((sum + BYTE_DATA) != 8'h00);
        end
    end
`else
    assign CHK_ERR = 1'b0;
`endif
endmodule

// File: tb/tb_imem_loader.sv
// Randomised self-checking bench for imem_loader with a queue-based write monitor
// and a byte-list reference model; honours IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;
    localparam int TP = 16;
    localparam int TW = 32;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam int CHK_EXTRA = 1;
`else
    localparam int CHK_EXTRA = 0;
`endif

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        START = 1'b0;
    logic [4:0]  LOAD_LEN = '0;
    logic        BYTE_VALID = 1'b0;
    logic [7:0]  BYTE_DATA = '0;
    logic        BYTE_READY, WE, BUSY, CPU_HOLD, DONE, CHK_ERR;
    logic [3:0]  WR_ADDRESS;
    logic [TW-1:0] WR_DATA;

    imem_loader #(.TAM_POSICIONES(TP), .TAM_PALABRA(TW)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .LOAD_LEN(LOAD_LEN),
        .BYTE_VALID(BYTE_VALID), .BYTE_DATA(BYTE_DATA), .BYTE_READY(BYTE_READY),
        .WE(WE), .WR_ADDRESS(WR_ADDRESS), .WR_DATA(WR_DATA), .BUSY(BUSY),
        .CPU_HOLD(CPU_HOLD), .DONE(DONE), .CHK_ERR(CHK_ERR)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int hold_cycles = 0;
    logic [3:0]    wa_q[$];
    logic [TW-1:0] wd_q[$];
    logic [7:0]    stim[$];

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (WE === 1'b1) begin
            wa_q.push_back(WR_ADDRESS);
            wd_q.push_back(WR_DATA);
        end
        if (CPU_HOLD === 1'b1) hold_cycles <= hold_cycles + 1;
    end

    // Reference: word w is bytes 4w..4w+3 with the first byte least significant.
    function automatic logic [TW-1:0] ref_word(input int w);
        logic [TW-1:0] v;
        v = '0;
        for (int k = 0; k < 4; k++) v = v | (TW'(stim[4*w+k]) << (8*k));
        return v;
    endfunction

    task automatic fill_stim(input int n, input bit rnd);
        stim.delete();
        for (int i = 0; i < n; i++) stim.push_back(rnd ? 8'($urandom) : 8'(i));
    endtask

    task automatic push_byte(input logic [7:0] b, input bit rnd, input bit pulse, output bit ok);
        int guard;
        guard = 0;
        ok = 1'b0;
        BYTE_DATA = b;
        if (pulse) begin
            START = 1'b1;
            LOAD_LEN = 5'd1;
        end
        while (!ok && guard < 100) begin
            BYTE_VALID = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge CLK);
            ok = BYTE_VALID && BYTE_READY;
            @(posedge CLK);
            #1;
            START = 1'b0;
            guard++;
        end
        BYTE_VALID = 1'b0;
    endtask

    task automatic run_load(input int len, input bit rnd, input int extra_at,
                            input int chk_byte, output int start_edge);
        bit ok;
        int nb;
        logic [7:0] s;
        nb = ((len > TP) ? TP : len) * 4;
        @(posedge CLK);
        #1;
        START = 1'b1;
        LOAD_LEN = 5'(len);
        @(negedge CLK);
        start_edge = cyc + 1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        s = '0;
        for (int i = 0; i < nb; i++) begin
            s = s + stim[i];
            push_byte(stim[i], rnd, i == extra_at, ok);
            if (!ok) begin
                n_tests++;
                n_fail++;
                $display("FAIL byte_handshake idx=%0d: got no handshake, required one", i);
                return;
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        push_byte((chk_byte < 0) ? 8'(-s) : 8'(chk_byte), rnd, 1'b0, ok);
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL checksum_handshake: got no handshake, required one");
        end
`else
        if (chk_byte > 255) $display("note: checksum byte ignored in this build");
`endif
    endtask

    task automatic wait_done(input int budget, output int edge_at);
        edge_at = -1;
        for (int n = 0; n < budget; n++) begin
            @(negedge CLK);
            if (DONE === 1'b1) begin
                edge_at = cyc;
                break;
            end
        end
        if (edge_at < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout: DONE stayed low for %0d cycles, required high", budget);
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        n_tests++;
        if ({BUSY, DONE, WE, BYTE_READY, CPU_HOLD, CHK_ERR} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b required 000000",
                     {BUSY, DONE, WE, BYTE_READY, CPU_HOLD, CHK_ERR});
        end
        n_tests++;
        if (WR_ADDRESS !== 4'h0 || WR_DATA !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_wr: got addr %h data %h required 0/0", WR_ADDRESS, WR_DATA);
        end
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
    endtask

    task automatic test_zero_len();
        int se, dc, base, h0;
        base = wa_q.size();
        h0 = hold_cycles;
        stim.delete();
        run_load(0, 1'b0, -1, -1, se);
`ifdef IMEM_LOADER_CHECKSUM_EN
        wait_done(20, dc);
`else
        @(negedge CLK);
        n_tests++;
        if (DONE !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_len_done: got %b required 1 one cycle after START", DONE);
        end
        repeat (3) @(negedge CLK);
        n_tests++;
        if (hold_cycles !== h0) begin
            n_fail++;
            $display("FAIL zero_len_hold: got %0d hold cycles required 0", hold_cycles - h0);
        end
`endif
        n_tests++;
        if (wa_q.size() !== base) begin
            n_fail++;
            $display("FAIL zero_len_we: got %0d writes required 0", wa_q.size() - base);
        end
    endtask

    task automatic test_basic();
        int se, dc, base;
        base = wa_q.size();
        fill_stim(12, 1'b0);
        run_load(3, 1'b0, -1, -1, se);
        wait_done(50, dc);
        n_tests++;
        if (dc - se !== 15 + CHK_EXTRA) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d cycles required %0d", dc - se, 15 + CHK_EXTRA);
        end
        n_tests++;
        if (wa_q.size() - base !== 3) begin
            n_fail++;
            $display("FAIL basic_count: got %0d writes required 3", wa_q.size() - base);
        end
        for (int w = 0; w < 3 && base + w < wa_q.size(); w++) begin
            n_tests++;
            if (wa_q[base+w] !== 4'(w) || wd_q[base+w] !== ref_word(w)) begin
                n_fail++;
                $display("FAIL basic_write%0d: got %h@%0d required %h@%0d",
                         w, wd_q[base+w], wa_q[base+w], ref_word(w), w);
            end
        end
        n_tests++;
        if (WR_ADDRESS !== 4'd2 || WR_DATA !== 32'h0B0A0908 ||
            {BUSY, BYTE_READY, CHK_ERR} !== 3'b0) begin
            n_fail++;
            $display("FAIL basic_fin: got addr %0d data %h busy/ready/err %b required 2 0b0a0908 000",
                     WR_ADDRESS, WR_DATA, {BUSY, BYTE_READY, CHK_ERR});
        end
    endtask

    task automatic test_random_valid();
        int se, dc, base;
        base = wa_q.size();
        fill_stim(12, 1'b0);
        run_load(3, 1'b1, 5, -1, se);
        wait_done(100, dc);
        n_tests++;
        if (wa_q.size() - base !== 3) begin
            n_fail++;
            $display("FAIL rnd_count: got %0d writes required 3", wa_q.size() - base);
        end
        for (int w = 0; w < 3 && base + w < wa_q.size(); w++) begin
            n_tests++;
            if (wa_q[base+w] !== 4'(w) || wd_q[base+w] !== ref_word(w)) begin
                n_fail++;
                $display("FAIL rnd_write%0d: got %h@%0d required %h@%0d",
                         w, wd_q[base+w], wa_q[base+w], ref_word(w), w);
            end
        end
    endtask

    task automatic test_random_len();
        int se, dc, base, len;
        for (int it = 0; it < 3; it++) begin
            len = $urandom_range(1, 6);
            base = wa_q.size();
            fill_stim(len * 4, 1'b1);
            run_load(len, 1'b1, -1, -1, se);
            wait_done(200, dc);
            n_tests++;
            if (wa_q.size() - base !== len) begin
                n_fail++;
                $display("FAIL rlen%0d_count: got %0d writes required %0d", it, wa_q.size() - base, len);
            end
            for (int w = 0; w < len && base + w < wa_q.size(); w++) begin
                n_tests++;
                if (wa_q[base+w] !== 4'(w) || wd_q[base+w] !== ref_word(w)) begin
                    n_fail++;
                    $display("FAIL rlen%0d_write%0d: got %h@%0d required %h@%0d",
                             it, w, wd_q[base+w], wa_q[base+w], ref_word(w), w);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int se, dc, base;
        fill_stim(12, 1'b0);
        @(posedge CLK);
        #1;
        START = 1'b1;
        LOAD_LEN = 5'd3;
        @(posedge CLK);
        #1;
        START = 1'b0;
        for (int i = 0; i < 6; i++) push_byte(stim[i], 1'b0, 1'b0, ok);
        RST_N = 1'b0;
        @(negedge CLK);
        n_tests++;
        if ({BUSY, BYTE_READY, DONE, WE} !== 4'b0) begin
            n_fail++;
            $display("FAIL midreset_ctrl: got %b required 0000", {BUSY, BYTE_READY, DONE, WE});
        end
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        base = wa_q.size();
        stim.delete();
        stim.push_back(8'hDD);
        stim.push_back(8'hCC);
        stim.push_back(8'hBB);
        stim.push_back(8'hAA);
        run_load(1, 1'b0, -1, -1, se);
        wait_done(30, dc);
        n_tests++;
        if (wa_q.size() - base !== 1) begin
            n_fail++;
            $display("FAIL midreset_count: got %0d writes required 1", wa_q.size() - base);
        end else begin
            n_tests++;
            if (wa_q[base] !== 4'd0 || wd_q[base] !== 32'hAABBCCDD) begin
                n_fail++;
                $display("FAIL midreset_write: got %h@%0d required aabbccdd@0", wd_q[base], wa_q[base]);
            end
        end
    endtask

    task automatic test_clamp();
        int se, dc, base;
        base = wa_q.size();
        fill_stim((TP + 5) * 4, 1'b1);
        run_load(TP + 5, 1'b0, -1, -1, se);
        wait_done(500, dc);
        n_tests++;
        if (wa_q.size() - base !== TP) begin
            n_fail++;
            $display("FAIL clamp_count: got %0d writes required %0d", wa_q.size() - base, TP);
        end
        for (int w = 0; w < TP && base + w < wa_q.size(); w++) begin
            n_tests++;
            if (wa_q[base+w] !== 4'(w) || wd_q[base+w] !== ref_word(w)) begin
                n_fail++;
                $display("FAIL clamp_write%0d: got %h@%0d required %h@%0d",
                         w, wd_q[base+w], wa_q[base+w], ref_word(w), w);
            end
        end
        n_tests++;
        if (WR_ADDRESS !== 4'(TP - 1)) begin
            n_fail++;
            $display("FAIL clamp_last_addr: got %0d required %0d", WR_ADDRESS, TP - 1);
        end
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        int se, dc;
        stim.delete();
        stim.push_back(8'h04);
        stim.push_back(8'h03);
        stim.push_back(8'h02);
        stim.push_back(8'h01);
        run_load(1, 1'b0, -1, 8'hF6, se);
        wait_done(30, dc);
        n_tests++;
        if (CHK_ERR !== 1'b0) begin
            n_fail++;
            $display("FAIL chk_good: got %b required 0", CHK_ERR);
        end
        run_load(1, 1'b0, -1, 8'hF7, se);
        wait_done(30, dc);
        n_tests++;
        if (CHK_ERR !== 1'b1) begin
            n_fail++;
            $display("FAIL chk_bad: got %b required 1", CHK_ERR);
        end
        @(posedge CLK);
        #1;
        START = 1'b1;
        LOAD_LEN = 5'd1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        @(negedge CLK);
        n_tests++;
        if (CHK_ERR !== 1'b0) begin
            n_fail++;
            $display("FAIL chk_clear: got %b required 0 after START", CHK_ERR);
        end
        RST_N = 1'b0;
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_zero_len();
        test_basic();
        test_random_valid();
        test_random_len();
        test_reset_mid();
        test_clamp();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
